// File: rtl/alu_mul_seq_if.sv
// Request/result handshake and ALU drive bus of the shift-and-add multiplier sequencer.
// The slave modport is the sequencer; the master modport is its environment (requester + ALU).
interface alu_mul_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   prod;
    logic [3:0]           alu_ctrl;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [WIDTH-1:0]     alu_res;

    modport master (
        output start, op_a, op_b, alu_res,
        input  busy, done, prod, alu_ctrl, alu_a, alu_b
    );

    modport slave (
        input  start, op_a, op_b, alu_res,
        output busy, done, prod, alu_ctrl, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier that borrows the shared ALU for its additions and
// shifts the multiplier right into the low half of the product.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_mul_seq_if.slave mul_if
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] CtrlAdd  = 4'b0010;
    localparam logic [3:0] CtrlIdle = 4'b1111;

    typedef enum logic [2:0] {StIdle, StAdd, StAcc, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;
    logic [3:0]           alu_ctrl;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [WIDTH-1:0]     sum;
    logic                 carry;

    // The ALU flags are not wired here, so rebuild the adder carry-out from the MSBs.
    assign sum   = mul_if.alu_res;
    assign carry = (acc_q[WIDTH-1] & mcand_q[WIDTH-1]) |
                   ((acc_q[WIDTH-1] | mcand_q[WIDTH-1]) & ~sum[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        done_d   = 1'b0;
        alu_ctrl = CtrlIdle;
        alu_a    = '0;
        alu_b    = '0;

        unique case (state_q)
            StIdle: begin
                if (mul_if.start) begin
                    acc_d   = '0;
                    lo_d    = mul_if.op_b;
                    mcand_d = mul_if.op_a;
                    cnt_d   = '0;
                    state_d = mul_if.op_b[0] ? StAdd : StShift;
                end
            end
            StAdd: begin
                alu_ctrl = CtrlAdd;
                alu_a    = acc_q;
                alu_b    = mcand_q;
                state_d  = StAcc;
            end
            StAcc:   {acc_d, lo_d} = {carry, sum, lo_q[WIDTH-1:1]};
            StShift: {acc_d, lo_d} = {1'b0, acc_q, lo_q[WIDTH-1:1]};
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Both ACC and SHIFT retire one multiplier bit; register the product so it and
        // done appear together in the DONE cycle.
        if (state_q == StAcc || state_q == StShift) begin
            if (cnt_q == CntW'(WIDTH - 1)) begin
                state_d = StDone;
                done_d  = 1'b1;
                prod_d  = {acc_d, lo_d};
            end else begin
                cnt_d   = cnt_q + CntW'(1);
                state_d = lo_d[0] ? StAdd : StShift;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign mul_if.busy     = (state_q != StIdle);
    assign mul_if.done     = done_q;
    assign mul_if.prod     = prod_q;
    assign mul_if.alu_ctrl = alu_ctrl;
    assign mul_if.alu_a    = alu_a;
    assign mul_if.alu_b    = alu_b;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised bench for alu_mul_seq: a behavioural ALU plus a reference of product,
// done latency (WIDTH + popcount + 1) and ADD count derived from the operands alone.
module tb_alu_mul_seq;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    alu_mul_seq_if #(.WIDTH(8)) bus ();

    alu_mul_seq #(.WIDTH(8)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .mul_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered 8-bit ALU: ADD code sums, any unused code yields zero.
    always @(posedge clk) begin
        bus.alu_res <= (bus.alu_ctrl == 4'b0010) ? bus.alu_a + bus.alu_b : 8'h00;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    // One multiplication. intr_cyc != 0 pulses a competing start in that cycle;
    // rst_cyc != 0 asserts reset in that cycle and checks the abort instead of the product.
    task automatic mul_run(input logic [7:0] a, input logic [7:0] b,
                           input int intr_cyc, input int rst_cyc);
        int cyc;
        int adds;
        bit seen;
        logic [15:0] exp_p;
        adds  = 0;
        seen  = 1'b0;
        exp_p = 16'(a) * 16'(b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = 8'($urandom);
        bus.op_b  = 8'($urandom);
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
                check_eq("abort_busy", 32'(bus.busy), 32'd0);
                check_eq("abort_done", 32'(bus.done), 32'd0);
                check_eq("abort_prod", 32'(bus.prod), 32'd0);
                check_eq("abort_ctrl", 32'(bus.alu_ctrl), 32'hF);
                rst = 1'b0;
                return;
            end
            if (bus.alu_ctrl == 4'b0010) begin
                adds++;
                check_eq("add_b", 32'(bus.alu_b), 32'(a));
            end else begin
                check_eq("idle_a", 32'(bus.alu_a), 32'd0);
            end
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            check_eq("busy_run", 32'(bus.busy), 32'd1);
            @(negedge clk);
            if (cyc == intr_cyc) begin
                bus.start = 1'b1;
                bus.op_a  = ~a;
                bus.op_b  = ~b;
            end
            if (cyc == rst_cyc) rst = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check_eq("done_cyc", 32'(cyc), 32'(9 + popc(b)));
            check_eq("prod", 32'(bus.prod), 32'(exp_p));
            check_eq("add_count", 32'(adds), 32'(popc(b)));
            check_eq("busy_done", 32'(bus.busy), 32'd1);
        end
        @(posedge clk);
        #1;
        check_eq("post_done", 32'(bus.done), 32'd0);
        check_eq("post_busy", 32'(bus.busy), 32'd0);
        check_eq("prod_hold", 32'(bus.prod), 32'(exp_p));
        check_eq("post_ctrl", 32'(bus.alu_ctrl), 32'hF);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = 8'h00;
        bus.op_b  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_prod", 32'(bus.prod), 32'd0);
        check_eq("rst_ctrl", 32'(bus.alu_ctrl), 32'hF);
        check_eq("rst_a", 32'(bus.alu_a), 32'd0);
        check_eq("rst_b", 32'(bus.alu_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        mul_run(8'h00, 8'h00, 0, 0);
        mul_run(8'hFF, 8'hFF, 0, 0);
        mul_run(8'h0D, 8'h0B, 0, 0);
        mul_run(8'h80, 8'h03, 0, 0);
        mul_run(8'h55, 8'hA3, 4, 0);
        mul_run(8'h12, 8'h34, 0, 0);
        mul_run(8'hFF, 8'hFF, 0, 5);
        mul_run(8'h02, 8'h03, 0, 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            mul_run(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
